// File: rtl/hc_pkg.sv
// hc_pkg: shared definitions for the hysteresis comparator array.
//   hc_state_t     per-channel state (LO, PEND_HI, HI, PEND_LO)
//   HC_W_DEF       default sample/threshold width
//   HC_TH_RST_DEF  default threshold loaded at reset
//   hc_is_high()   decodes the output flag from a channel state
package hc_pkg;

    typedef enum logic [1:0] {
        LO      = 2'd0,
        PEND_HI = 2'd1,
        HI      = 2'd2,
        PEND_LO = 2'd3
    } hc_state_t;

    localparam int HC_W_DEF      = 8;
    localparam int HC_TH_RST_DEF = 10;

    // The flag stays asserted while a falling transition is still pending.
    function automatic logic hc_is_high(input hc_state_t s);
        return (s == HI) || (s == PEND_LO);
    endfunction

endpackage

// File: rtl/hc_chan.sv
// hc_chan: one hysteresis comparator channel.
//   Set when a > b + th, clear when b > a + th (W+1-bit sums, strict).
//   Optional debounce (macro HC_DEBOUNCE_EN): DB_CYCLES consecutive
//   qualifying valid samples are needed before the flag switches.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       sample qualifier; invalid cycles hold state and count
//   a, b           unsigned samples
//   th             current threshold
//   out            registered "a above b" flag
//   change         one-cycle pulse in the first cycle out shows a new value
module hc_chan
    import hc_pkg::*;
#(
    parameter int W         = HC_W_DEF,
    parameter int DB_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] th,
    output logic         out,
    output logic         change
);

    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_range_err
        $error("hc_chan: DB_CYCLES must be in 1..255");
    end

    // Evaluated one bit wider than the operands so x + t can never wrap.
    function automatic logic exceeds(input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     input logic [W-1:0] t);
        logic [W:0] lhs;
        logic [W:0] rhs;
        lhs = {1'b0, x};
        rhs = {1'b0, y} + {1'b0, t};
        return lhs > rhs;
    endfunction

    logic      set_c;
    logic      clr_c;
    hc_state_t state_p1;
    hc_state_t state_nxt;
    logic      change_p1;

    assign set_c = exceeds(a, b, th);
    assign clr_c = exceeds(b, a, th);

`ifdef HC_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DB_CYCLES);

    logic [CW-1:0] cnt_p1;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_p1 + CW'(1);

    always_comb begin
        state_nxt = state_p1;
        cnt_nxt   = cnt_p1;
        if (in_valid) begin
            case (state_p1)
                LO: begin
                    if (set_c) begin
                        if (DB_CYCLES == 1) begin
                            state_nxt = HI;
                        end else begin
                            state_nxt = PEND_HI;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                PEND_HI: begin
                    if (!set_c) begin
                        state_nxt = LO;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_nxt = HI;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt_inc;
                    end
                end
                HI: begin
                    if (clr_c) begin
                        if (DB_CYCLES == 1) begin
                            state_nxt = LO;
                        end else begin
                            state_nxt = PEND_LO;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                PEND_LO: begin
                    if (!clr_c) begin
                        state_nxt = HI;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_nxt = LO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else begin
            cnt_p1 <= cnt_nxt;
        end
    end
`else
    always_comb begin
        state_nxt = state_p1;
        if (in_valid) begin
            case (state_p1)
                LO:      if (set_c) state_nxt = HI;
                HI:      if (clr_c) state_nxt = LO;
                default: state_nxt = LO;
            endcase
        end
    end
`endif

    // Stage 1: state and change-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1  <= LO;
            change_p1 <= 1'b0;
        end else begin
            state_p1  <= state_nxt;
            change_p1 <= hc_is_high(state_nxt) != hc_is_high(state_p1);
        end
    end

    assign out    = hc_is_high(state_p1);
    assign change = change_p1;

endmodule

// File: rtl/hyst_cmp_array.sv
// hyst_cmp_array: N independent hysteresis comparators sharing one
// runtime-programmable threshold and a common valid qualifier.
// Optional per-channel debounce is built when HC_DEBOUNCE_EN is defined.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       samples valid for all channels this cycle
//   a, b           N packed W-bit unsigned samples, channel i at [i*W +: W]
//   cfg_we, th_in  threshold load; a sample in the same cycle sees the old value
//   out            per-channel registered flag (1 = A above B)
//   change         per-channel one-cycle toggle pulse
//   any_out        OR of out
module hyst_cmp_array
    import hc_pkg::*;
#(
    parameter int W         = HC_W_DEF,
    parameter int N         = 4,
    parameter int TH_RST    = HC_TH_RST_DEF,
    parameter int DB_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    input  logic           cfg_we,
    input  logic [W-1:0]   th_in,
    output logic [N-1:0]   out,
    output logic [N-1:0]   change,
    output logic           any_out
);

    logic [W-1:0] th_p1;

    // Stage 1: threshold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            th_p1 <= W'(TH_RST);
        end else if (cfg_we) begin
            th_p1 <= th_in;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        hc_chan #(
            .W         (W),
            .DB_CYCLES (DB_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .a        (a[i*W +: W]),
            .b        (b[i*W +: W]),
            .th       (th_p1),
            .out      (out[i]),
            .change   (change[i])
        );
    end

    assign any_out = |out;

endmodule

// File: doc/hyst_cmp_array.md
# hyst_cmp_array

Parametrised multi-channel hysteresis comparator: N independent channels, each comparing a sample pair (a, b) against a runtime-programmable threshold and holding a registered "a above b" flag with hysteresis. It extends the single-channel fixed-threshold 8-bit comparator with configurable width and channel count, overflow-safe arithmetic, a valid qualifier, change-event pulses and optional per-channel debounce. It sits between the sensor sampling front end and the control/alarm logic.

## Interface
- W, 8, sample and threshold width in bits
- N, 4, number of channels
- TH_RST, 10, threshold value loaded at reset
- DB_CYCLES, 3, consecutive qualifying valid samples required to switch (debounce builds only; range 1..255)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  a/b samples on this cycle are valid for all channels
- a  in  N*W  channel i sample A at bits [i*W +: W], unsigned
- b  in  N*W  channel i sample B at bits [i*W +: W], unsigned
- cfg_we  in  1  load th_in into the threshold register
- th_in  in  W  new threshold, unsigned
- out  out  N  registered per-channel state, 1 = A above B
- change  out  N  one-cycle pulse on the cycle out[i] toggles
- any_out  out  1  OR of out, combinational from out registers

## Operation
- Set condition: a > b + th. Clear condition: b > a + th. Both sums are computed in W+1 bits; no wrap-around is permitted. Equality at the boundary does not qualify.
- Per-channel states: LO, PEND_HI, HI, PEND_LO. out = 1 in HI and PEND_LO.
- LO: set on a valid sample -> PEND_HI with count 1, or directly HI if DB_CYCLES = 1.
- PEND_HI: set on a valid sample -> increment count; at DB_CYCLES -> HI. A valid sample without set -> LO, count cleared.
- HI and PEND_LO mirror this using the clear condition.
- in_valid = 0: state and count hold; gaps neither advance nor reset debounce.
- Samples with neither condition true (inside the band) leave LO and HI unchanged.
- cfg_we: th register loads th_in at the clock edge. A sample presented in the same cycle uses the old threshold.
- Channels are fully independent; they share only th and in_valid.

## Timing
- Reset: out = 0, change = 0, any_out = 0, all states LO, counts 0, th = TH_RST.
- rst during PEND_* returns the channel to LO with out = 0 on the next cycle. rst takes priority over cfg_we and in_valid.
- Latency without debounce: the sample valid in cycle t gives out updated in cycle t+1.
- With debounce: out updates in the cycle after the DB_CYCLES-th consecutive qualifying valid sample.
- change[i] is registered and high in exactly the first cycle in which out[i] shows its new value.

## Configuration
- HC_DEBOUNCE_EN defined: PEND states, per-channel ceil(log2(DB_CYCLES+1))-bit counters and DB_CYCLES are active.
- HC_DEBOUNCE_EN undefined: PEND states and counters are not built. Transitions are LO <-> HI directly on one qualifying valid sample. DB_CYCLES is ignored.

## Structure
- Package hc_pkg: channel state enum (LO, PEND_HI, HI, PEND_LO) and the default W and TH_RST constants.
- Sub-module hc_chan holds one channel's state machine, counter, set/clear arithmetic and change register. hyst_cmp_array owns the th register, slices the buses and instantiates N copies via generate.

## Test plan
- Reset: hold rst 2 cycles with a = 200, b = 0 valid -> out = 0, change = 0, th = 10 throughout reset; release -> out[0] = 1 after 1 cycle (no debounce) or after DB_CYCLES valid samples (debounce build).
- Strict threshold, no debounce: ch0 a = 100, b = 90 -> out stays 0. a = 100, b = 89 -> out[0] = 1 next cycle, change[0] pulses 1 cycle, any_out = 1. a = 95, b = 100 (in band) -> stays 1. a = 80, b = 91 -> out[0] = 0 with change pulse.
- No wrap: th = 10. a = 3, b = 0 -> out stays 0. a = 255, b = 250 -> stays 0. a = 255, b = 244 -> set; then a = 0, b = 9 -> stays 1.
- Debounce (DB_CYCLES = 3): two qualifying valid samples, one in-band sample, then three qualifying -> out rises only after the final third. Qualifying samples separated by in_valid = 0 gaps still rise after the third.
- Threshold update: cfg_we with th_in = 20 in the same cycle as a = 115, b = 100 valid -> set occurs (old th = 10). The same sample on the next cycle after clearing does not set.
- Multichannel and reset: ch1 in PEND_HI, ch2 HI, then rst -> all out = 0 next cycle. Other channels are unaffected by ch0 stimulus throughout.
